// File: rtl/core1_pkg.sv
// Shared core1 definitions: fetch-queue FSM states, instruction word geometry
// and the field split seen by the downstream splitter.
package core1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ifq_state_t;

  localparam int WORD_W      = 32;
  localparam int INSTR_ALIGN = 4;
  localparam int IMM16_LSB   = 0;
  localparam int FIELD8_LSB  = 16;
  localparam int FLAG_BIT    = 24;

  typedef struct packed {
    logic        flag;
    logic [7:0]  field8;
    logic [15:0] imm16;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [WORD_W-1:0] w);
    instr_fields_t f;
    f.imm16  = w[IMM16_LSB +: 16];
    f.field8 = w[FIELD8_LSB +: 8];
    f.flag   = w[FLAG_BIT];
    return f;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// In-order prefetch storage for the fetch queue: DEPTH entries of {pc, word},
// wrapping pointers, occupancy count and a single-cycle flush.
module ifq_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  // Storage carries no reset; the top gates every read with the count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// core1 fetch stage: sequential word fetch, in-order prefetch queue, redirect flush.
// Build option IFQ_BYPASS_EN forwards a response straight to the consumer when the queue is empty.
module instr_fetch_queue
  import core1_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr_word,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output ifq_state_t        dbg_state
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  ifq_state_t              state, state_nx;
  logic [ADDR_W-1:0]       pc, resp_pc, head_pc;
  logic [WORD_W-1:0]       head_word;
  logic [CNT_W-1:0]        outstanding, drop_cnt, out_nx, drop_nx, occ;
  logic                    grant, resp, accept, push, pop, q_valid;

  // Handshakes: a transfer happens on a cycle where valid & ready (mem_req & mem_gnt,
  // instr_valid & instr_ready); responses carry no ready and arrive in request order.
  assign grant   = mem_req & mem_gnt;
  assign resp    = mem_rvalid & (outstanding != '0);
  assign accept  = resp & (drop_cnt == '0) & ~redirect_valid;
  assign out_nx  = outstanding + CNT_W'(grant) - CNT_W'(resp);
  assign q_valid = (occ != '0);

  always_comb begin
    drop_nx = drop_cnt;
    if (redirect_valid)               drop_nx = out_nx;
    else if (resp && drop_cnt != '0)  drop_nx = drop_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = RUN;
      RUN: begin
        if (redirect_valid && out_nx != '0)       state_nx = FLUSH;
        else if (!enable && outstanding == '0)    state_nx = IDLE;
      end
      FLUSH:   if (drop_nx == '0) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Credit rule: queued plus in-flight words never exceed the queue depth.
  always_comb begin
    mem_req   = enable && (state != IDLE) &&
                ((SUM_W'(occ) + SUM_W'(outstanding)) < SUM_W'(DEPTH));
    mem_addr  = pc;
    dbg_state = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nx;
      drop_cnt    <= drop_nx;
      if (redirect_valid) begin
        pc      <= redirect_pc & ~ADDR_W'(INSTR_ALIGN - 1);
        resp_pc <= redirect_pc & ~ADDR_W'(INSTR_ALIGN - 1);
      end else begin
        if (grant)  pc      <= pc + ADDR_W'(INSTR_ALIGN);
        if (accept) resp_pc <= resp_pc + ADDR_W'(INSTR_ALIGN);
      end
    end
  end

  ifq_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (WORD_W + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({resp_pc, mem_rdata}),
    .rdata ({head_pc, head_word}),
    .count (occ)
  );

  assign pop = q_valid & instr_ready;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass      = !q_valid && (state == RUN) && accept;
  assign push        = accept && !(bypass && instr_ready);
  assign instr_valid = q_valid || bypass;
  assign instr_word  = q_valid ? head_word : (bypass ? mem_rdata : '0);
  assign instr_pc    = q_valid ? head_pc   : (bypass ? resp_pc   : '0);
`else
  assign push        = accept;
  assign instr_valid = q_valid;
  assign instr_word  = q_valid ? head_word : '0;
  assign instr_pc    = q_valid ? head_pc   : '0;
`endif

  // A response with nothing outstanding is a protocol violation by the memory.
  assert property (@(posedge clk) disable iff (rst) !(mem_rvalid && outstanding == '0));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a random phase,
// all compared against a queue-based reference model of the fetch stage.
module tb_instr_fetch_queue;
  import core1_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, enable, redirect_valid, mem_req, mem_gnt, mem_rvalid;
  logic        instr_valid, instr_ready;
  logic [31:0] redirect_pc, mem_addr, mem_rdata, instr_word, instr_pc;
  ifq_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_word(instr_word), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .dbg_state(dbg_state)
  );

  // reference model: fetch pc, in-flight requests (stale after a redirect), queued words
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } qe_t;
  fl_t         inflight[$];
  qe_t         mq[$];
  logic [31:0] mpc;
  bit          active;

  // memory environment: pending reads with their due cycle
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [31:0] salt = 32'h0;
  int          lat_min = 1, lat_max = 1, last_due = 0;

  logic [31:0] deliv[$];
  logic        obs_valid, obs_req;
  logic [31:0] obs_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int stale_cnt();
    int n = 0;
    foreach (inflight[i]) if (inflight[i].stale) n++;
    return n;
  endfunction

  task automatic cycle(input bit en, input bit redir, input logic [31:0] rpc,
                       input bit rdy, input int gnt_pct);
    int          n_out, due;
    bit          exp_req, resp, keep, byp, exp_valid;
    logic [31:0] exp_w, exp_p;
    ifq_state_t  exp_st;
    fl_t         e;
    enable         = en;
    redirect_valid = redir;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    mem_gnt        = ($urandom_range(0, 99) < gnt_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend[0].addr ^ salt;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    @(negedge clk);
    n_out     = inflight.size();
    exp_req   = en && active && (mq.size() + n_out < DEPTH);
    resp      = mem_rvalid && n_out > 0;
    keep      = resp && !inflight[0].stale && !redir;
    byp       = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp       = keep && mq.size() == 0 && active && stale_cnt() == 0;
`endif
    exp_valid = (mq.size() > 0) || byp;
    exp_w     = 32'h0;
    exp_p     = 32'h0;
    if (mq.size() > 0) begin
      exp_w = mq[0].word;
      exp_p = mq[0].pc;
    end else if (byp) begin
      exp_p = inflight[0].pc;
      exp_w = inflight[0].pc ^ salt;
    end
    exp_st = !active ? IDLE : (stale_cnt() > 0 ? FLUSH : RUN);
    chk("mem_req", 64'(mem_req), 64'(exp_req));
    chk("mem_addr", 64'(mem_addr), 64'(mpc));
    chk("instr_valid", 64'(instr_valid), 64'(exp_valid));
    chk("state", 64'(dbg_state), 64'(exp_st));
    if (exp_valid) begin
      chk("instr_word", 64'(instr_word), 64'(exp_w));
      chk("instr_pc", 64'(instr_pc), 64'(exp_p));
    end
    obs_valid = instr_valid;
    obs_word  = instr_word;
    obs_req   = mem_req;
    if (instr_valid && rdy) deliv.push_back(instr_pc);
    // environment
    if (mem_rvalid) void'(pend.pop_front());
    if (mem_req && mem_gnt) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due < last_due) due = last_due;
      last_due = due;
      pend.push_back('{mem_addr, due});
    end
    // reference model
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (resp) begin
      e = inflight.pop_front();
      if (keep && !(byp && rdy)) mq.push_back('{e.pc, e.pc ^ salt});
    end
    if (redir) mq.delete();
    if (exp_req && mem_gnt) begin
      inflight.push_back('{mpc, 1'b0});
      mpc += 32'd4;
    end
    if (redir) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      mpc = rpc & ~32'h3;
    end
    active = active ? (en || n_out > 0) : en;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; redirect_valid = 1'b0;
    mem_rvalid = 1'b0; mem_gnt = 1'b0; instr_ready = 1'b0;
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(RESET_PC));
    chk("rst_instr_valid", 64'(instr_valid), 64'(0));
    chk("rst_instr_word", 64'(instr_word), 64'(0));
    chk("rst_instr_pc", 64'(instr_pc), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    pend.delete(); inflight.delete(); mq.delete();
    mpc = RESET_PC; active = 1'b0; last_due = cyc;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (inflight.size() > 0 || mq.size() > 0); i++) cycle(1, 0, 0, 1, 0);
    chk("drain_done", 64'(inflight.size() + mq.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; instr_ready = 1'b0;
    #1;
    do_reset();

    // sequential fetch, grant always, 1-cycle responses, rdata = pc
    deliv.delete();
    repeat (20) cycle(1, 0, 0, 1, 100);
    chk("seq_count_ok", 64'(deliv.size() >= 3), 64'(1));
    if (deliv.size() >= 3)
      for (int i = 0; i < 3; i++) chk("seq_pc", 64'(deliv[i]), 64'(i * 4));

    // consumer stalls: queue fills, requests stop, nothing lost afterwards
    repeat (10) cycle(1, 0, 0, 0, 100);
    chk("stall_req_low", 64'(obs_req), 64'(0));
    chk("stall_valid", 64'(obs_valid), 64'(1));
    repeat (10) cycle(1, 0, 0, 1, 100);

    // two requests in flight, then redirect to 0x100 (low bits ignored)
    drain();
    lat_min = 3; lat_max = 3;
    cycle(1, 0, 0, 1, 100);
    cycle(1, 0, 0, 1, 100);
    deliv.delete();
    cycle(1, 1, 32'h102, 1, 0);
    lat_min = 1; lat_max = 1;
    repeat (12) cycle(1, 0, 0, 1, 100);
    chk("redir_count_ok", 64'(deliv.size() >= 2), 64'(1));
    if (deliv.size() >= 2) begin
      chk("redir_first_pc", 64'(deliv[0]), 64'(32'h100));
      chk("redir_second_pc", 64'(deliv[1]), 64'(32'h104));
    end

    // push and pop together with a well-filled queue
    salt = 32'hC0DE_0000;
    for (int i = 0; i < 24; i++) cycle(1, 0, 0, (i % 3) != 0, 100);

    // reset pulse mid-operation, fetch restarts at RESET_PC
    lat_min = 2; lat_max = 2;
    repeat (5) cycle(1, 0, 0, 0, 100);
    do_reset();
    lat_min = 1; lat_max = 1;
    deliv.delete();
    repeat (8) cycle(1, 0, 0, 1, 100);
    chk("post_rst_count_ok", 64'(deliv.size() >= 1), 64'(1));
    if (deliv.size() >= 1) chk("post_rst_first_pc", 64'(deliv[0]), 64'(RESET_PC));

`ifdef IFQ_BYPASS_EN
    drain();
    cycle(1, 0, 0, 1, 100);
    chk("bypass_setup", 64'(pend.size()), 64'(1));
    if (pend.size() == 1) begin
      salt = pend[0].addr ^ 32'h01AB_1234;
      cycle(1, 0, 0, 1, 0);
      chk("bypass_valid", 64'(obs_valid), 64'(1));
      chk("bypass_imm16", 64'(obs_word[15:0]), 64'(16'h1234));
      chk("bypass_field8", 64'(obs_word[23:16]), 64'(8'hAB));
      chk("bypass_flag", 64'(obs_word[24]), 64'(1));
    end
`endif

    // random traffic: enable drops, redirects, variable latency, consumer stalls
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      if ((i % 200) == 0) salt = $urandom;
      cycle($urandom_range(0, 15) != 0, $urandom_range(0, 39) == 0, $urandom,
            $urandom_range(0, 3) != 0, 70);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
